serial_add_ctrl: RTL

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: a+b+cin is formed LSB first through a single full adder,
// sequenced by an IDLE/ADD/DONE controller. One result every WIDTH+2 cycles.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_sh, b_sh, res_sh, res_nxt;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               fa_s, fa_co;
  logic               last_bit;

  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // New sum bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
  always_comb begin
    res_nxt = (res_sh >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ADD;
      ADD:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            carry <= cin;
            cnt   <= '0;
          end
        end
        ADD: begin
          carry <= fa_co;
          cnt   <= cnt + CNT_W'(1);
          if (last_bit) begin
            sum  <= res_nxt;
            cout <= fa_co;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand and partial-result shifters carry no reset; they are only observed through sum/cout.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_sh <= a;
      b_sh <= b;
    end else if (state == ADD) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_nxt;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
